// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit
// per clock under a start/done handshake; divide-by-zero completes in one cycle.
module seq_div #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] q,
    output logic [W-1:0]   r,
    output logic           dbz
);

    localparam int CW = (2 * W > 1) ? $clog2(2 * W) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state, state_next;
    logic [2*W-1:0] dividend;
    logic [2*W-1:0] qacc;
    logic [W-1:0]   divisor;
    logic [W:0]     rem;
    logic [W:0]     trial;
    logic [W:0]     rem_next;
    logic [CW-1:0]  cnt;
    logic           qbit;
    logic           accept;
    logic           zero_div;
    logic           last;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_div   = 1'b0;
        last       = 1'b0;
        trial      = {rem[W-1:0], dividend[cnt]};
        qbit       = (trial >= {1'b0, divisor});
        rem_next   = qbit ? (trial - {1'b0, divisor}) : trial;

        case (state)
            IDLE: begin
                if (start) begin
                    if (b != '0) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        zero_div = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            dbz      <= 1'b0;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            qacc     <= '0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                dividend <= a;
                divisor  <= b;
                rem      <= '0;
                qacc     <= '0;
                cnt      <= CW'(2 * W - 1);
                busy     <= 1'b1;
            end

            if (zero_div) begin
                q    <= '1;
                r    <= a[W-1:0];
                dbz  <= 1'b1;
                done <= 1'b1;
            end

            if (state == RUN) begin
                rem  <= rem_next;
                qacc <= {qacc[2*W-2:0], qbit};
                if (last) begin
                    // Result is taken from this cycle's step, not the registers.
                    q    <= {qacc[2*W-2:0], qbit};
                    r    <= rem_next[W-1:0];
                    dbz  <= 1'b0;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule
